// File: rtl/multicycle_ctrl.sv
// Multicycle processor control FSM: fetch/decode/execute sequencing with
// memory wait states, a per-access timeout and a sticky fault state.
module multicycle_ctrl #(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] op,
    input  logic       funct_i,
    input  logic       funct_l,
    input  logic       cond_ok,
    input  logic       mem_ready,
    output logic       pc_en,
    output logic       ir_en,
    output logic       data_en,
    output logic       reg_we,
    output logic       mem_req,
    output logic       mem_we,
    output logic       adr_sel,
    output logic       alu_src_imm,
    output logic       pc_src_br,
    output logic       fault,
    output logic [3:0] state
);

    localparam int CW = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);
    localparam logic [CW-1:0] WAIT_MAX = CW'(MEM_TIMEOUT);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXECR  = 4'd6,
        S_EXECI  = 4'd7,
        S_ALUWB  = 4'd8,
        S_BRANCH = 4'd9,
        S_FAULT  = 4'd15
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] wait_q, wait_d;
    logic          timeout;
    logic          pc_en_raw, ir_en_raw;
    logic          is_wait;

    assign timeout = (wait_q == WAIT_MAX);
    assign state   = state_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_FETCH;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        pc_en_raw   = 1'b0;
        ir_en_raw   = 1'b0;
        data_en     = 1'b0;
        reg_we      = 1'b0;
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        adr_sel     = 1'b0;
        alu_src_imm = 1'b0;
        pc_src_br   = 1'b0;
        fault       = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    ir_en_raw = 1'b1;
                    pc_en_raw = 1'b1;
                    state_d   = S_DECODE;
                end else if (timeout) begin
                    state_d = S_FAULT;
                end
            end
            S_DECODE: begin
                case (op)
                    2'b00:   state_d = funct_i ? S_EXECI : S_EXECR;
                    2'b01:   state_d = S_MEMADR;
                    2'b10:   state_d = S_BRANCH;
                    default: state_d = S_FAULT;
                endcase
            end
            S_MEMADR: begin
                alu_src_imm = 1'b1;
                state_d     = funct_l ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                mem_req = 1'b1;
                adr_sel = 1'b1;
                if (mem_ready) begin
                    data_en = 1'b1;
                    state_d = S_MEMWB;
                end else if (timeout) begin
                    state_d = S_FAULT;
                end
            end
            S_MEMWB: begin
                reg_we  = 1'b1;
                state_d = S_FETCH;
            end
            S_MEMWR: begin
                mem_req = 1'b1;
                mem_we  = 1'b1;
                adr_sel = 1'b1;
                if (mem_ready) begin
                    state_d = S_FETCH;
                end else if (timeout) begin
                    state_d = S_FAULT;
                end
            end
            S_EXECR: state_d = S_ALUWB;
            S_EXECI: begin
                alu_src_imm = 1'b1;
                state_d     = S_ALUWB;
            end
            S_ALUWB: begin
                reg_we  = 1'b1;
                state_d = S_FETCH;
            end
            S_BRANCH: begin
                pc_src_br = 1'b1;
                pc_en_raw = cond_ok;
                state_d   = S_FETCH;
            end
            S_FAULT: fault = 1'b1;
            default: state_d = S_FAULT;
        endcase
    end

    // The counter only runs while a wait state holds itself; any transition clears it.
    assign is_wait = (state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR);

    always_comb begin
        wait_d = '0;
        if (is_wait && (state_d == state_q)) begin
            wait_d = timeout ? wait_q : wait_q + 1'b1;
        end
    end

    // Reset parks the FSM in FETCH, so the fetch enables must be gated explicitly.
    assign pc_en = pc_en_raw & ~reset;
    assign ir_en = ir_en_raw & ~reset;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: directed vector table, hand-written wait/timeout/
// reset sequences, and randomized cycles against an instruction-level model.
module tb_multicycle_ctrl;

    localparam int T = 15;

    localparam logic [9:0] O_PC    = 10'b1000000000;
    localparam logic [9:0] O_IR    = 10'b0100000000;
    localparam logic [9:0] O_DATA  = 10'b0010000000;
    localparam logic [9:0] O_REGWE = 10'b0001000000;
    localparam logic [9:0] O_MREQ  = 10'b0000100000;
    localparam logic [9:0] O_MWE   = 10'b0000010000;
    localparam logic [9:0] O_ADR   = 10'b0000001000;
    localparam logic [9:0] O_ALUI  = 10'b0000000100;
    localparam logic [9:0] O_PCBR  = 10'b0000000010;
    localparam logic [9:0] O_FAULT = 10'b0000000001;
    localparam logic [9:0] O_NONE  = 10'b0000000000;

    localparam int M_FETCH = 0, M_DECODE = 1, M_MEMADR = 2, M_MEMRD = 3, M_MEMWB = 4;
    localparam int M_MEMWR = 5, M_EXECR = 6, M_EXECI = 7, M_ALUWB = 8, M_BRANCH = 9;
    localparam int M_FAULT = 15;

    logic       clk, reset;
    logic [1:0] op;
    logic       funct_i, funct_l, cond_ok, mem_ready;
    logic       pc_en, ir_en, data_en, reg_we, mem_req, mem_we;
    logic       adr_sel, alu_src_imm, pc_src_br, fault;
    logic [3:0] state;
    logic [9:0] dut_outs;

    int n_cmp = 0;
    int n_err = 0;

    multicycle_ctrl #(.MEM_TIMEOUT(T)) dut (
        .clk(clk), .reset(reset), .op(op), .funct_i(funct_i), .funct_l(funct_l),
        .cond_ok(cond_ok), .mem_ready(mem_ready), .pc_en(pc_en), .ir_en(ir_en),
        .data_en(data_en), .reg_we(reg_we), .mem_req(mem_req), .mem_we(mem_we),
        .adr_sel(adr_sel), .alu_src_imm(alu_src_imm), .pc_src_br(pc_src_br),
        .fault(fault), .state(state)
    );

    assign dut_outs = {pc_en, ir_en, data_en, reg_we, mem_req, mem_we,
                       adr_sel, alu_src_imm, pc_src_br, fault};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [1:0] op;
        logic       fi, fl, cok, rdy;
        logic [3:0] st;
        logic [9:0] outs;
    } vec_t;

    vec_t vtab[$];

    task automatic add(input logic [1:0] o, input logic fi, input logic fl,
                       input logic cok, input logic rdy, input logic [3:0] st,
                       input logic [9:0] outs);
        vec_t v;
        v.op = o; v.fi = fi; v.fl = fl; v.cok = cok; v.rdy = rdy; v.st = st; v.outs = outs;
        vtab.push_back(v);
    endtask

    task automatic drive(input logic [1:0] o, input logic fi, input logic fl,
                         input logic cok, input logic rdy);
        op = o; funct_i = fi; funct_l = fl; cond_ok = cok; mem_ready = rdy;
    endtask

    task automatic check(input string name, input logic [3:0] exp_st, input logic [9:0] exp_outs);
        n_cmp++;
        if (state !== exp_st || dut_outs !== exp_outs) begin
            n_err++;
            $display("FAIL %s: got state=%0d outs=%b, want state=%0d outs=%b",
                     name, state, dut_outs, exp_st, exp_outs);
        end
    endtask

    // Entered 1 time unit after a rising edge; checks mid-cycle, returns after the next edge.
    task automatic cyc(input string name, input logic [3:0] exp_st, input logic [9:0] exp_outs);
        #4;
        check(name, exp_st, exp_outs);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #4;
        check("reset_hold", 4'd0, O_MREQ);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // Instruction-level reference model.
    int m_state, m_wait;

    function automatic logic [9:0] model_outs(int st, logic rdy, logic cok, logic rst);
        logic [9:0] o;
        o = O_NONE;
        case (st)
            M_FETCH:           o = O_MREQ | ((rdy && !rst) ? (O_PC | O_IR) : O_NONE);
            M_MEMADR, M_EXECI: o = O_ALUI;
            M_MEMRD:           o = O_MREQ | O_ADR | (rdy ? O_DATA : O_NONE);
            M_MEMWB, M_ALUWB:  o = O_REGWE;
            M_MEMWR:           o = O_MREQ | O_MWE | O_ADR;
            M_BRANCH:          o = O_PCBR | (cok ? O_PC : O_NONE);
            M_FAULT:           o = O_FAULT;
            default:           o = O_NONE;
        endcase
        return o;
    endfunction

    task automatic model_step(input logic [1:0] o, input logic fi, input logic fl,
                              input logic rdy, input logic rst);
        int nxt;
        if (rst) begin
            m_state = M_FETCH;
            m_wait  = 0;
            return;
        end
        nxt = m_state;
        case (m_state)
            M_FETCH, M_MEMRD, M_MEMWR: begin
                if (rdy) nxt = (m_state == M_FETCH) ? M_DECODE :
                               (m_state == M_MEMRD) ? M_MEMWB : M_FETCH;
                else if (m_wait >= T) nxt = M_FAULT;
            end
            M_DECODE: nxt = (o == 2'b00) ? (fi ? M_EXECI : M_EXECR) :
                            (o == 2'b01) ? M_MEMADR :
                            (o == 2'b10) ? M_BRANCH : M_FAULT;
            M_MEMADR: nxt = fl ? M_MEMRD : M_MEMWR;
            M_EXECR, M_EXECI: nxt = M_ALUWB;
            M_MEMWB, M_ALUWB, M_BRANCH: nxt = M_FETCH;
            default: nxt = M_FAULT;
        endcase
        m_wait  = (nxt == m_state && nxt != M_FAULT) ? m_wait + 1 : 0;
        m_state = nxt;
    endtask

    initial begin
        int pct;
        logic [1:0] r_op;
        logic r_fi, r_fl, r_cok, r_rdy, r_rst;

        reset = 1'b0;
        drive(2'b00, 1'b0, 1'b0, 1'b0, 1'b1);
        #1 reset = 1'b1;
        #4;
        check("reset_async", 4'd0, O_MREQ);
        @(posedge clk);
        #1;
        check("reset_gated", 4'd0, O_MREQ);
        reset = 1'b0;

        // op fi fl cok rdy  state  outputs (checked before the edge)
        add(2'b00, 0, 0, 0, 1, 4'd0, O_PC | O_IR | O_MREQ);
        add(2'b00, 0, 0, 0, 1, 4'd1, O_NONE);
        add(2'b00, 0, 0, 0, 1, 4'd6, O_NONE);
        add(2'b00, 0, 0, 0, 1, 4'd8, O_REGWE);
        add(2'b00, 1, 0, 0, 1, 4'd0, O_PC | O_IR | O_MREQ);
        add(2'b00, 1, 0, 0, 1, 4'd1, O_NONE);
        add(2'b00, 1, 0, 0, 1, 4'd7, O_ALUI);
        add(2'b00, 1, 0, 0, 1, 4'd8, O_REGWE);
        add(2'b01, 0, 1, 0, 1, 4'd0, O_PC | O_IR | O_MREQ);
        add(2'b01, 0, 1, 0, 1, 4'd1, O_NONE);
        add(2'b01, 0, 1, 0, 1, 4'd2, O_ALUI);
        add(2'b01, 0, 1, 0, 1, 4'd3, O_MREQ | O_ADR | O_DATA);
        add(2'b01, 0, 1, 0, 1, 4'd4, O_REGWE);
        add(2'b01, 0, 0, 0, 1, 4'd0, O_PC | O_IR | O_MREQ);
        add(2'b01, 0, 0, 0, 1, 4'd1, O_NONE);
        add(2'b01, 0, 0, 0, 1, 4'd2, O_ALUI);
        add(2'b01, 0, 0, 0, 1, 4'd5, O_MREQ | O_MWE | O_ADR);
        add(2'b10, 0, 0, 1, 1, 4'd0, O_PC | O_IR | O_MREQ);
        add(2'b10, 0, 0, 1, 1, 4'd1, O_NONE);
        add(2'b10, 0, 0, 1, 1, 4'd9, O_PC | O_PCBR);
        add(2'b10, 0, 0, 0, 1, 4'd0, O_PC | O_IR | O_MREQ);
        add(2'b10, 0, 0, 0, 1, 4'd1, O_NONE);
        add(2'b10, 0, 0, 0, 1, 4'd9, O_PCBR);
        add(2'b00, 0, 0, 0, 0, 4'd0, O_MREQ);
        add(2'b00, 0, 0, 0, 1, 4'd0, O_PC | O_IR | O_MREQ);
        add(2'b00, 0, 0, 0, 1, 4'd1, O_NONE);

        foreach (vtab[i]) begin
            drive(vtab[i].op, vtab[i].fi, vtab[i].fl, vtab[i].cok, vtab[i].rdy);
            cyc($sformatf("vec%0d", i), vtab[i].st, vtab[i].outs);
        end

        // Load with three wait cycles in MEMRD.
        do_reset();
        drive(2'b01, 1'b0, 1'b1, 1'b0, 1'b1);
        cyc("ldw_fetch", 4'd0, O_PC | O_IR | O_MREQ);
        cyc("ldw_decode", 4'd1, O_NONE);
        cyc("ldw_memadr", 4'd2, O_ALUI);
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) cyc("ldw_wait", 4'd3, O_MREQ | O_ADR);
        mem_ready = 1'b1;
        cyc("ldw_done", 4'd3, O_MREQ | O_ADR | O_DATA);
        cyc("ldw_memwb", 4'd4, O_REGWE);

        // FETCH timeout: 16 edges without mem_ready, then sticky FAULT.
        do_reset();
        mem_ready = 1'b0;
        for (int i = 0; i < 16; i++) cyc("fto_wait", 4'd0, O_MREQ);
        cyc("fto_fault", 4'd15, O_FAULT);
        drive(2'b00, 1'b0, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) cyc("fto_sticky", 4'd15, O_FAULT);

        // mem_ready arriving exactly at the timeout count wins.
        do_reset();
        drive(2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 15; i++) cyc("edge_wait", 4'd0, O_MREQ);
        mem_ready = 1'b1;
        cyc("edge_ready", 4'd0, O_PC | O_IR | O_MREQ);
        cyc("edge_decode", 4'd1, O_NONE);

        // Counter restarts on entering MEMWR after an earlier FETCH wait.
        do_reset();
        drive(2'b01, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) cyc("swto_fwait", 4'd0, O_MREQ);
        mem_ready = 1'b1;
        cyc("swto_fetch", 4'd0, O_PC | O_IR | O_MREQ);
        cyc("swto_decode", 4'd1, O_NONE);
        cyc("swto_memadr", 4'd2, O_ALUI);
        mem_ready = 1'b0;
        for (int i = 0; i < 16; i++) cyc("swto_wait", 4'd5, O_MREQ | O_MWE | O_ADR);
        cyc("swto_fault", 4'd15, O_FAULT);

        // Undefined opcode.
        do_reset();
        drive(2'b11, 1'b0, 1'b0, 1'b0, 1'b1);
        cyc("undef_fetch", 4'd0, O_PC | O_IR | O_MREQ);
        cyc("undef_decode", 4'd1, O_NONE);
        cyc("undef_fault", 4'd15, O_FAULT);

        // Asynchronous reset in the middle of a stalled store.
        do_reset();
        drive(2'b01, 1'b0, 1'b0, 1'b0, 1'b1);
        cyc("arst_fetch", 4'd0, O_PC | O_IR | O_MREQ);
        cyc("arst_decode", 4'd1, O_NONE);
        cyc("arst_memadr", 4'd2, O_ALUI);
        mem_ready = 1'b0;
        #4;
        check("arst_memwr", 4'd5, O_MREQ | O_MWE | O_ADR);
        reset = 1'b1;
        #1;
        check("arst_now", 4'd0, O_MREQ);
        mem_ready = 1'b1;
        #1;
        check("arst_gate", 4'd0, O_MREQ);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Randomized cycles against the model.
        m_state = M_FETCH;
        m_wait  = 0;
        for (int c = 0; c < 3000; c++) begin
            case ((c / 150) % 3)
                0:       pct = 90;
                1:       pct = 50;
                default: pct = 3;
            endcase
            r_op  = 2'($urandom_range(0, 3));
            r_fi  = 1'($urandom_range(0, 1));
            r_fl  = 1'($urandom_range(0, 1));
            r_cok = 1'($urandom_range(0, 1));
            r_rdy = ($urandom_range(0, 99) < pct);
            r_rst = (m_state == M_FAULT && $urandom_range(0, 3) == 0) ||
                    ($urandom_range(0, 299) == 0);
            drive(r_op, r_fi, r_fl, r_cok, r_rdy);
            reset = r_rst;
            if (r_rst) begin
                m_state = M_FETCH;
                m_wait  = 0;
            end
            #4;
            check($sformatf("rand%0d", c), 4'(m_state), model_outs(m_state, r_rdy, r_cok, r_rst));
            @(posedge clk);
            model_step(r_op, r_fi, r_fl, r_rdy, r_rst);
            #1;
        end
        reset = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 The block SHALL have one parameter: MEM_TIMEOUT, default 15, the maximum number of consecutive wait cycles allowed on a memory access before the controller faults.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 op  input  2  instruction class from the IR: 00 data-processing, 01 memory, 10 branch, 11 undefined.
REQ-005 funct_i  input  1  data-processing immediate-operand flag.
REQ-006 funct_l  input  1  memory load (1) / store (0) flag.
REQ-007 cond_ok  input  1  condition check passed; sampled only in BRANCH.
REQ-008 mem_ready  input  1  memory completes the current access this cycle.
REQ-009 pc_en  output  1  enable for the 32-bit PC enabled flop.
REQ-010 ir_en  output  1  enable for the 32-bit IR enabled flop.
REQ-011 data_en  output  1  enable for the 32-bit read-data enabled flop.
REQ-012 reg_we  output  1  register-file write enable.
REQ-013 mem_req  output  1  memory access request.
REQ-014 mem_we  output  1  memory write; valid only with mem_req.
REQ-015 adr_sel  output  1  memory address source: 0 = PC, 1 = ALU result.
REQ-016 alu_src_imm  output  1  ALU operand B selects the immediate.
REQ-017 pc_src_br  output  1  PC next value selects the branch target.
REQ-018 fault  output  1  sticky error indication.
REQ-019 state  output  4  current state encoding, exposed for debug.

Function
REQ-020 The state encoding SHALL be: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECR=6, EXECI=7, ALUWB=8, BRANCH=9, FAULT=15; codes 10-14 SHALL go to FAULT on the next edge.
REQ-021 FETCH: mem_req=1, adr_sel=0; while mem_ready=1, ir_en=1 and pc_en=1 combinationally, and the next state is DECODE; otherwise the block stays in FETCH.
REQ-022 DECODE: op=00 goes to EXECI if funct_i=1, else EXECR; op=01 goes to MEMADR; op=10 goes to BRANCH; op=11 goes to FAULT.
REQ-023 EXECR goes to ALUWB with alu_src_imm=0; EXECI goes to ALUWB with alu_src_imm=1; ALUWB asserts reg_we=1 and goes to FETCH.
REQ-024 MEMADR: alu_src_imm=1; goes to MEMRD if funct_l=1, else MEMWR.
REQ-025 MEMRD: mem_req=1, adr_sel=1; while mem_ready=1, data_en=1 and the next state is MEMWB; otherwise the block stays in MEMRD.
REQ-026 MEMWB: reg_we=1; goes to FETCH.
REQ-027 MEMWR: mem_req=1, mem_we=1, adr_sel=1; on mem_ready=1 goes to FETCH; otherwise the block stays in MEMWR.
REQ-028 BRANCH: pc_src_br=1 and pc_en=cond_ok; goes to FETCH unconditionally.
REQ-029 Any output not named for a state SHALL be 0 in that state.
REQ-030 Wait states (FETCH, MEMRD, MEMWR) SHALL use a wait counter of width clog2(MEM_TIMEOUT+1) bits.
- Counter is cleared on entry to a wait state.
- Counter increments each cycle with mem_ready=0.
- Counter saturates at MEM_TIMEOUT.
REQ-031 If the counter equals MEM_TIMEOUT and mem_ready=0, the next state SHALL be FAULT; mem_ready=1 in that same cycle SHALL complete the access normally, taking priority over the timeout.
REQ-032 FAULT: fault=1, all enables 0; FAULT is left only by reset.
REQ-033 Only pc_en, ir_en and data_en SHALL depend combinationally on mem_ready or cond_ok; all other outputs SHALL be pure functions of state.

Reset
REQ-034 Asserting reset SHALL force state=FETCH, wait counter=0 and fault=0 immediately, regardless of clk, including mid-access.
REQ-035 During reset, mem_req=1 and adr_sel=0 (FETCH decode), with pc_en and ir_en gated to 0.

Verification
REQ-036 Data-processing register instruction: mem_ready=1 constantly, op=00, funct_i=0 -> sequence FETCH, DECODE, EXECR, ALUWB, FETCH; reg_we=1 only in cycle 4.
REQ-037 Load and store with mem_ready=1:
- op=01, funct_l=1 -> 5-cycle loop ending in MEMWB; data_en=1 in MEMRD.
- funct_l=0 -> 4-cycle loop; mem_we=1 only in MEMWR.
REQ-038 Branch: op=10 with cond_ok=1 -> pc_en=1 and pc_src_br=1 in BRANCH; repeat with cond_ok=0 -> pc_en=0 and the block returns to FETCH.
REQ-039 Memory wait states:
- mem_ready=0 for 3 cycles in MEMRD, then 1 -> state=3 for 4 cycles, then MEMWB, fault=0.
- mem_ready held 0 in FETCH -> FAULT after the 16th cycle edge (MEM_TIMEOUT=15), fault=1 sticky.
REQ-040 Undefined op and reset:
- op=11 in DECODE -> FAULT next cycle.
- Asserting reset asynchronously mid-MEMWR -> state=0 and mem_we=0 before the next clk edge.
